alu_sequencer: RTL and testbench

//   Multicycle control unit for the 16-bit processor datapath.
//   - Accepts one instruction word at a time over a valid/ready handshake.
//   - Decodes it and sequences register-file reads, ALU opSelect, immediate muxing and writeback.
//   - Maintains the PC and a zero flag.
//   - Sits between the instruction source and the regfile+ALU datapath; owns all of its control.

---
 rtl/proc_pkg.sv | 42 ++++
 rtl/seq_decode.sv | 37 +++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the 16-bit processor control path: opcodes, ALU ops,
// sequencer states and instruction field positions.
package proc_pkg;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_SUB  = 4'h1,
    OPC_NAN  = 4'h2,
    OPC_MOV  = 4'h3,
    OPC_LDI  = 4'h4,
    OPC_JMP  = 4'h5,
    OPC_BZ   = 4'h6,
    OPC_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_NAND  = 2'b10,
    OP_PASSB = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RA_MSB  = 7;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_MSB  = 3;
  localparam int unsigned RB_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: maps the IR opcode to ALU/immediate controls
// and the instruction-class flags the sequencer FSM branches on.
module seq_decode
  import proc_pkg::*;
(
  input  logic [3:0] opc_i,
  output logic [1:0] op_sel_o,
  output logic       imm_sel_o,
  output logic       writes_reg_o,
  output logic       sets_flag_o,
  output logic       is_jump_o,
  output logic       is_bz_o,
  output logic       is_halt_o
);

  always_comb begin
    op_sel_o     = OP_ADD;
    imm_sel_o    = 1'b0;
    writes_reg_o = 1'b0;
    sets_flag_o  = 1'b0;
    is_jump_o    = 1'b0;
    is_bz_o      = 1'b0;
    is_halt_o    = 1'b0;
    case (opc_i)
      OPC_ADD: begin op_sel_o = OP_ADD;   writes_reg_o = 1'b1; sets_flag_o = 1'b1; end
      OPC_SUB: begin op_sel_o = OP_SUB;   writes_reg_o = 1'b1; sets_flag_o = 1'b1; end
      OPC_NAN: begin op_sel_o = OP_NAND;  writes_reg_o = 1'b1; sets_flag_o = 1'b1; end
      OPC_MOV: begin op_sel_o = OP_PASSB; writes_reg_o = 1'b1; end
      OPC_LDI: begin op_sel_o = OP_PASSB; writes_reg_o = 1'b1; imm_sel_o = 1'b1; end
      OPC_JMP:  is_jump_o = 1'b1;
      OPC_BZ:   is_bz_o   = 1'b1;
      OPC_HALT: is_halt_o = 1'b1;
      default: ; // 7..E are NOPs
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle control unit: accepts instructions over valid/ready and sequences
// regfile reads, ALU op selection, immediate muxing, writeback, PC and zero flag.
module alu_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned RA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instrValid,
  input  logic [15:0]     instrData,
  output logic            instrReady,
  input  logic [15:0]     aluResult,
  output logic [RA_W-1:0] rdAddrA,
  output logic [RA_W-1:0] rdAddrB,
  output logic [1:0]      opSelect,
  output logic            immSelect,
  output logic [15:0]     immData,
  output logic            wrEnable,
  output logic [RA_W-1:0] wrAddr,
  output logic [PC_W-1:0] pc,
  output logic            zeroFlag,
  output logic            halted
);

  state_e          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;

  logic [1:0]      dec_op;
  logic            dec_imm, dec_writes, dec_sets_flag, dec_jump, dec_bz, dec_halt;
  logic            ready, drive, wr;
  logic [PC_W-1:0] imm_ext;

  seq_decode u_decode (
    .opc_i        (ir_q[OPC_MSB:OPC_LSB]),
    .op_sel_o     (dec_op),
    .imm_sel_o    (dec_imm),
    .writes_reg_o (dec_writes),
    .sets_flag_o  (dec_sets_flag),
    .is_jump_o    (dec_jump),
    .is_bz_o      (dec_bz),
    .is_halt_o    (dec_halt)
  );

  assign imm_ext = PC_W'(ir_q[IMM_MSB:IMM_LSB]);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    zero_d  = zero_q;
    ready   = 1'b0;
    drive   = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ready = 1'b1;
        if (instrValid) begin
          ir_d    = instrData;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        drive = 1'b1;
        if (dec_halt) begin
          state_d = S_HALT;
        end else if (dec_jump || dec_bz) begin
          // A taken branch replaces the +1 applied at accept.
          if (dec_jump || zero_q) pc_d = imm_ext;
          state_d = S_FETCH;
        end else if (dec_writes) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        drive   = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        drive = 1'b1;
        wr    = 1'b1;
        if (dec_sets_flag) zero_d = (aluResult == 16'h0000);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      zero_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
    end
  end

  // Outputs are forced low while reset is high so an aborted WB never strobes.
  assign instrReady = ~reset & ready;
  assign rdAddrA    = (drive && !reset) ? RA_W'(ir_q[RA_MSB:RA_LSB]) : '0;
  assign rdAddrB    = (drive && !reset) ? RA_W'(ir_q[RB_MSB:RB_LSB]) : '0;
  assign opSelect   = (drive && !reset) ? dec_op : '0;
  assign immSelect  = drive & ~reset & dec_imm;
  assign immData    = (drive && !reset) ? {8'h00, ir_q[IMM_MSB:IMM_LSB]} : '0;
  assign wrEnable   = wr & ~reset;
  assign wrAddr     = (wr && !reset) ? RA_W'(ir_q[RD_MSB:RD_LSB]) : '0;
  assign pc         = reset ? '0 : pc_q;
  assign zeroFlag   = ~reset & zero_q;
  assign halted     = ~reset & (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed expectations per scenario.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [15:0] instrData;
  logic        instrReady;
  logic [15:0] aluResult;
  logic [3:0]  rdAddrA, rdAddrB, wrAddr;
  logic [1:0]  opSelect;
  logic        immSelect;
  logic [15:0] immData;
  logic        wrEnable;
  logic [7:0]  pc;
  logic        zeroFlag;
  logic        halted;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(8), .RA_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instrValid (instrValid),
    .instrData  (instrData),
    .instrReady (instrReady),
    .aluResult  (aluResult),
    .rdAddrA    (rdAddrA),
    .rdAddrB    (rdAddrB),
    .opSelect   (opSelect),
    .immSelect  (immSelect),
    .immData    (immData),
    .wrEnable   (wrEnable),
    .wrAddr     (wrAddr),
    .pc         (pc),
    .zeroFlag   (zeroFlag),
    .halted     (halted)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Waits (bounded) for instrReady, presents one word for one cycle, returns in DECODE.
  task automatic issue(input logic [15:0] w);
    int unsigned waited = 0;
    while (instrReady !== 1'b1 && waited < 8) begin
      step(1);
      waited++;
    end
    n_cmp++;
    if (instrReady !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout instr=%h instrReady=%b expected 1", w, instrReady);
    end
    instrValid = 1'b1;
    instrData  = w;
    step(1);
    instrValid = 1'b0;
    instrData  = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; instrValid = 1'b1; instrData = 16'h50AA; aluResult = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_cmp++;
      if ({instrReady, rdAddrA, rdAddrB, opSelect, immSelect, immData, wrEnable, wrAddr, pc, zeroFlag, halted} !== 43'h0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i,
          {instrReady, rdAddrA, rdAddrB, opSelect, immSelect, immData, wrEnable, wrAddr, pc, zeroFlag, halted});
      end
    end
    reset = 1'b0; instrValid = 1'b0;
    #1;
    n_cmp++;
    if ({instrReady, pc, halted} !== {1'b1, 8'h00, 1'b0}) begin
      n_err++; $display("FAIL reset_release got rdy/pc/halt=%b/%h/%b exp 1/00/0", instrReady, pc, halted);
    end
  endtask

  task automatic test_ldi_sub();
    aluResult = 16'h0005;
    issue(16'h4105);
    n_cmp++;
    if ({rdAddrB, opSelect, immSelect, immData, pc, instrReady, wrEnable} !== {4'h5, 2'b11, 1'b1, 16'h0005, 8'h01, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL ldi_decode got rb=%h op=%b imm=%b immd=%h pc=%h rdy=%b we=%b exp 5 11 1 0005 01 0 0",
        rdAddrB, opSelect, immSelect, immData, pc, instrReady, wrEnable);
    end
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr, instrReady} !== {1'b1, 4'h1, 1'b0}) begin
      n_err++; $display("FAIL ldi1_wb got we=%b wa=%h rdy=%b exp 1 1 0", wrEnable, wrAddr, instrReady);
    end
    step(1);
    n_cmp++;
    if ({instrReady, wrEnable} !== 2'b10) begin
      n_err++; $display("FAIL ldi1_cycle4 got rdy=%b we=%b exp 1 0", instrReady, wrEnable);
    end
    aluResult = 16'h0003;
    issue(16'h4203);
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr} !== {1'b1, 4'h2}) begin
      n_err++; $display("FAIL ldi2_wb got we=%b wa=%h exp 1 2", wrEnable, wrAddr);
    end
    step(1);
    aluResult = 16'h0002;
    issue(16'h1312);
    n_cmp++;
    if ({rdAddrA, rdAddrB, opSelect, immSelect, pc} !== {4'h1, 4'h2, 2'b01, 1'b0, 8'h03}) begin
      n_err++; $display("FAIL sub_decode got ra=%h rb=%h op=%b imm=%b pc=%h exp 1 2 01 0 03",
        rdAddrA, rdAddrB, opSelect, immSelect, pc);
    end
    step(1);
    n_cmp++;
    if ({wrEnable, rdAddrA, rdAddrB, opSelect} !== {1'b0, 4'h1, 4'h2, 2'b01}) begin
      n_err++; $display("FAIL sub_exec_hold got we=%b ra=%h rb=%h op=%b exp 0 1 2 01", wrEnable, rdAddrA, rdAddrB, opSelect);
    end
    step(1);
    n_cmp++;
    if ({wrEnable, wrAddr, opSelect} !== {1'b1, 4'h3, 2'b01}) begin
      n_err++; $display("FAIL sub_wb got we=%b wa=%h op=%b exp 1 3 01", wrEnable, wrAddr, opSelect);
    end
    step(1);
    n_cmp++;
    if ({zeroFlag, wrEnable, wrAddr, instrReady} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
      n_err++; $display("FAIL sub_after got z=%b we=%b wa=%h rdy=%b exp 0 0 0 1", zeroFlag, wrEnable, wrAddr, instrReady);
    end
  endtask

  task automatic test_bz_taken();
    aluResult = 16'h0000;
    issue(16'h1411);
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr} !== {1'b1, 4'h4}) begin
      n_err++; $display("FAIL sub0_wb got we=%b wa=%h exp 1 4", wrEnable, wrAddr);
    end
    step(1);
    n_cmp++;
    if (zeroFlag !== 1'b1) begin
      n_err++; $display("FAIL sub0_flag got z=%b exp 1", zeroFlag);
    end
    issue(16'h6040);
    n_cmp++;
    if ({pc, instrReady, wrEnable} !== {8'h05, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL bz_decode got pc=%h rdy=%b we=%b exp 05 0 0", pc, instrReady, wrEnable);
    end
    step(1);
    n_cmp++;
    if ({pc, instrReady} !== {8'h40, 1'b1}) begin
      n_err++; $display("FAIL bz_taken got pc=%h rdy=%b exp 40 1", pc, instrReady);
    end
  endtask

  task automatic test_idle_bz_not_taken();
    instrValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_cmp++;
      if ({pc, instrReady, wrEnable} !== {8'h40, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL idle cyc=%0d got pc=%h rdy=%b we=%b exp 40 1 0", i, pc, instrReady, wrEnable);
      end
    end
    aluResult = 16'h0008;
    issue(16'h0512);
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr, opSelect} !== {1'b1, 4'h5, 2'b00}) begin
      n_err++; $display("FAIL add_wb got we=%b wa=%h op=%b exp 1 5 00", wrEnable, wrAddr, opSelect);
    end
    step(1);
    n_cmp++;
    if ({zeroFlag, pc} !== {1'b0, 8'h41}) begin
      n_err++; $display("FAIL add_flag got z=%b pc=%h exp 0 41", zeroFlag, pc);
    end
    issue(16'h6020);
    n_cmp++;
    if (pc !== 8'h42) begin
      n_err++; $display("FAIL bz_nt_decode got pc=%h exp 42", pc);
    end
    step(1);
    n_cmp++;
    if ({pc, instrReady} !== {8'h42, 1'b1}) begin
      n_err++; $display("FAIL bz_not_taken got pc=%h rdy=%b exp 42 1", pc, instrReady);
    end
  endtask

  task automatic test_ops();
    aluResult = 16'h0000;
    issue(16'h3607);
    n_cmp++;
    if ({opSelect, immSelect, rdAddrB, pc} !== {2'b11, 1'b0, 4'h7, 8'h43}) begin
      n_err++; $display("FAIL mov_decode got op=%b imm=%b rb=%h pc=%h exp 11 0 7 43", opSelect, immSelect, rdAddrB, pc);
    end
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr} !== {1'b1, 4'h6}) begin
      n_err++; $display("FAIL mov_wb got we=%b wa=%h exp 1 6", wrEnable, wrAddr);
    end
    step(1);
    n_cmp++;
    if (zeroFlag !== 1'b0) begin
      n_err++; $display("FAIL mov_noflag got z=%b exp 0", zeroFlag);
    end
    aluResult = 16'h0000;
    issue(16'h2789);
    n_cmp++;
    if ({opSelect, rdAddrA, rdAddrB} !== {2'b10, 4'h8, 4'h9}) begin
      n_err++; $display("FAIL nan_decode got op=%b ra=%h rb=%h exp 10 8 9", opSelect, rdAddrA, rdAddrB);
    end
    step(3);
    n_cmp++;
    if (zeroFlag !== 1'b1) begin
      n_err++; $display("FAIL nan_flag got z=%b exp 1", zeroFlag);
    end
    aluResult = 16'h007F;
    issue(16'h4A7F);
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr, immData} !== {1'b1, 4'hA, 16'h007F}) begin
      n_err++; $display("FAIL ldi_wb got we=%b wa=%h immd=%h exp 1 a 007f", wrEnable, wrAddr, immData);
    end
    step(1);
    n_cmp++;
    if ({zeroFlag, pc} !== {1'b1, 8'h45}) begin
      n_err++; $display("FAIL ldi_noflag got z=%b pc=%h exp 1 45", zeroFlag, pc);
    end
    issue(16'h7ABC);
    n_cmp++;
    if ({pc, wrEnable, instrReady} !== {8'h46, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL nop_decode got pc=%h we=%b rdy=%b exp 46 0 0", pc, wrEnable, instrReady);
    end
    step(1);
    n_cmp++;
    if ({instrReady, wrEnable} !== 2'b10) begin
      n_err++; $display("FAIL nop_return got rdy=%b we=%b exp 1 0", instrReady, wrEnable);
    end
    issue(16'hE123);
    step(1);
    n_cmp++;
    if ({instrReady, pc, zeroFlag} !== {1'b1, 8'h47, 1'b1}) begin
      n_err++; $display("FAIL nopE got rdy=%b pc=%h z=%b exp 1 47 1", instrReady, pc, zeroFlag);
    end
  endtask

  task automatic test_wrap_halt();
    issue(16'h50FF);
    step(1);
    n_cmp++;
    if ({pc, instrReady} !== {8'hFF, 1'b1}) begin
      n_err++; $display("FAIL jmp_ff got pc=%h rdy=%b exp ff 1", pc, instrReady);
    end
    issue(16'h7000);
    n_cmp++;
    if (pc !== 8'h00) begin
      n_err++; $display("FAIL pc_wrap got pc=%h exp 00", pc);
    end
    step(1);
    issue(16'h5010);
    step(1);
    n_cmp++;
    if ({pc, instrReady} !== {8'h10, 1'b1}) begin
      n_err++; $display("FAIL jmp_10 got pc=%h rdy=%b exp 10 1", pc, instrReady);
    end
    issue(16'hF000);
    n_cmp++;
    if ({halted, pc} !== {1'b0, 8'h11}) begin
      n_err++; $display("FAIL halt_decode got halted=%b pc=%h exp 0 11", halted, pc);
    end
    instrValid = 1'b1; instrData = 16'h4155;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_cmp++;
      if ({halted, instrReady, wrEnable, pc} !== {1'b1, 1'b0, 1'b0, 8'h11}) begin
        n_err++; $display("FAIL halt_hold cyc=%0d got halt=%b rdy=%b we=%b pc=%h exp 1 0 0 11", i, halted, instrReady, wrEnable, pc);
      end
    end
    instrValid = 1'b0;
  endtask

  task automatic test_reset_in_wb();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    aluResult = 16'h0000;
    issue(16'h1000);
    step(3);
    n_cmp++;
    if ({zeroFlag, halted, pc} !== {1'b1, 1'b0, 8'h01}) begin
      n_err++; $display("FAIL pre_abort got z=%b halt=%b pc=%h exp 1 0 01", zeroFlag, halted, pc);
    end
    issue(16'h0123);
    step(2);
    n_cmp++;
    if ({wrEnable, wrAddr} !== {1'b1, 4'h1}) begin
      n_err++; $display("FAIL add_wb_pre got we=%b wa=%h exp 1 1", wrEnable, wrAddr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({wrEnable, wrAddr} !== 5'h00) begin
      n_err++; $display("FAIL abort_wb got we=%b wa=%h exp 0 0", wrEnable, wrAddr);
    end
    step(1);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({instrReady, pc, zeroFlag, halted, wrEnable} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL abort_state got rdy=%b pc=%h z=%b halt=%b we=%b exp 1 00 0 0 0",
        instrReady, pc, zeroFlag, halted, wrEnable);
    end
    step(1);
    n_cmp++;
    if ({wrEnable, instrReady, pc} !== {1'b0, 1'b1, 8'h00}) begin
      n_err++; $display("FAIL abort_idle got we=%b rdy=%b pc=%h exp 0 1 00", wrEnable, instrReady, pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instrValid = 1'b0; instrData = 16'h0000; aluResult = 16'h0000;
    test_reset();
    test_ldi_sub();
    test_bz_taken();
    test_idle_bz_not_taken();
    test_ops();
    test_wrap_halt();
    test_reset_in_wb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
